// File: rtl/gc_sync_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gc_sync_responder                                                          |
// | Filtered Muller C-element answering the gC Start/Sensor/Actuator handshake.|
// | Optional handshake counter: define GC_SYNC_RESPONDER_HSCOUNT_EN.           |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module gc_sync_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int RISE_DLY    = 4,
  parameter int FALL_DLY    = 3,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Start,
  input  logic        Sensor,
  output logic        Actuator,
  output logic        busy
`ifdef GC_SYNC_RESPONDER_HSCOUNT_EN
  ,
  output logic [15:0] hs_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE_LO = 2'd0,
    ST_ARM     = 2'd1,
    ST_HIGH    = 2'd2,
    ST_DISARM  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_RISE_LAST = CNT_W'(RISE_DLY - 1);
  localparam logic [CNT_W-1:0] c_FALL_LAST = CNT_W'(FALL_DLY - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync_start;
  logic [SYNC_STAGES-1:0] r_sync_sensor;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_actuator;
  logic                   r_busy;

  logic                   w_both_hi;
  logic                   w_both_lo;
  logic [CNT_W-1:0]       w_cnt_inc;
  logic                   w_hs_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_start  <= '0;
      r_sync_sensor <= '0;
    end else begin
      r_sync_start  <= {r_sync_start[SYNC_STAGES-2:0], Start};
      r_sync_sensor <= {r_sync_sensor[SYNC_STAGES-2:0], Sensor};
    end
  end

  assign w_both_hi = r_sync_start[SYNC_STAGES-1] & r_sync_sensor[SYNC_STAGES-1];
  assign w_both_lo = ~r_sync_start[SYNC_STAGES-1] & ~r_sync_sensor[SYNC_STAGES-1];
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign w_hs_done = (r_state == ST_DISARM) && w_both_lo && (r_cnt >= c_FALL_LAST);

  // Actuator and busy are updated alongside the state so both are clean flop outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE_LO;
      r_cnt      <= '0;
      r_actuator <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE_LO: begin
          r_actuator <= 1'b0;
          if (w_both_hi) begin
            if (RISE_DLY == 1) begin
              r_state    <= ST_HIGH;
              r_cnt      <= '0;
              r_actuator <= 1'b1;
              r_busy     <= 1'b0;
            end else begin
              r_state <= ST_ARM;
              r_cnt   <= c_CNT_ONE;
              r_busy  <= 1'b1;
            end
          end else begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
          end
        end
        ST_ARM: begin
          if (w_both_hi) begin
            if (r_cnt >= c_RISE_LAST) begin
              r_state    <= ST_HIGH;
              r_cnt      <= '0;
              r_actuator <= 1'b1;
              r_busy     <= 1'b0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end else begin
            r_state    <= ST_IDLE_LO;
            r_cnt      <= '0;
            r_actuator <= 1'b0;
            r_busy     <= 1'b0;
          end
        end
        ST_HIGH: begin
          r_actuator <= 1'b1;
          // One input low alone never releases the output: C-element hysteresis.
          if (w_both_lo) begin
            if (FALL_DLY == 1) begin
              r_state    <= ST_IDLE_LO;
              r_cnt      <= '0;
              r_actuator <= 1'b0;
              r_busy     <= 1'b0;
            end else begin
              r_state <= ST_DISARM;
              r_cnt   <= c_CNT_ONE;
              r_busy  <= 1'b1;
            end
          end else begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
          end
        end
        ST_DISARM: begin
          if (w_both_lo) begin
            if (r_cnt >= c_FALL_LAST) begin
              r_state    <= ST_IDLE_LO;
              r_cnt      <= '0;
              r_actuator <= 1'b0;
              r_busy     <= 1'b0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end else begin
            r_state    <= ST_HIGH;
            r_cnt      <= '0;
            r_actuator <= 1'b1;
            r_busy     <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE_LO;
          r_cnt      <= '0;
          r_actuator <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign Actuator = r_actuator;
  assign busy     = r_busy;

`ifdef GC_SYNC_RESPONDER_HSCOUNT_EN
  logic [15:0] r_hs_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_count <= '0;
    end else if (w_hs_done && !(&r_hs_count)) begin
      r_hs_count <= r_hs_count + 16'd1;
    end
  end

  assign hs_count = r_hs_count;
`else
  logic w_unused_hs;
  assign w_unused_hs = w_hs_done;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gc_sync_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gc_sync_responder                                                       |
// | Scoreboard bench: expected Actuator edges queued at stimulus time.         |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_gc_sync_responder;

  typedef struct {
    int   cyc;
    logic val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic Start, Sensor;
  logic act, bsy;
  logic byp_act, byp_bsy;
  logic ch_start, ch_sensor;
  logic c0_act, c1_act, c2_act;
  logic c0_bsy, c1_bsy, c2_bsy;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb_main[$];
  exp_t sb_chain[$];
  logic main_prev = 1'b0;
  logic chain_prev = 1'b0;

`ifdef GC_SYNC_RESPONDER_HSCOUNT_EN
  logic [15:0] hs, byp_hs, c0_hs, c1_hs, c2_hs;
  int exp_hs = 0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gc_sync_responder u_dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Sensor(Sensor),
    .Actuator(act), .busy(bsy)
`ifdef GC_SYNC_RESPONDER_HSCOUNT_EN
    , .hs_count(hs)
`endif
  );

  gc_sync_responder #(.RISE_DLY(1), .FALL_DLY(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Sensor(Sensor),
    .Actuator(byp_act), .busy(byp_bsy)
`ifdef GC_SYNC_RESPONDER_HSCOUNT_EN
    , .hs_count(byp_hs)
`endif
  );

  gc_sync_responder u_c0 (
    .clk(clk), .rst_n(rst_n), .Start(ch_start), .Sensor(ch_sensor),
    .Actuator(c0_act), .busy(c0_bsy)
`ifdef GC_SYNC_RESPONDER_HSCOUNT_EN
    , .hs_count(c0_hs)
`endif
  );

  gc_sync_responder u_c1 (
    .clk(clk), .rst_n(rst_n), .Start(c0_act), .Sensor(ch_sensor),
    .Actuator(c1_act), .busy(c1_bsy)
`ifdef GC_SYNC_RESPONDER_HSCOUNT_EN
    , .hs_count(c1_hs)
`endif
  );

  gc_sync_responder u_c2 (
    .clk(clk), .rst_n(rst_n), .Start(c1_act), .Sensor(ch_sensor),
    .Actuator(c2_act), .busy(c2_bsy)
`ifdef GC_SYNC_RESPONDER_HSCOUNT_EN
    , .hs_count(c2_hs)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_main(input int dly, input logic v);
    exp_t e;
    e.cyc = cyc + dly;
    e.val = v;
    sb_main.push_back(e);
  endtask

  task automatic drain_main(input int budget);
    int k = 0;
    while (sb_main.size() > 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (sb_main.size() > 0) begin
      check("main_drain_timeout", sb_main.size(), 0);
      sb_main.delete();
    end
  endtask

  // Each observed Actuator edge must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      main_prev = act;
    end else if (act !== main_prev) begin
      if (sb_main.size() == 0) begin
        check("main_unexpected_edge", act, main_prev);
      end else begin
        exp_t e;
        e = sb_main.pop_front();
        check("main_edge_cycle", cyc, e.cyc);
        check("main_edge_value", act, e.val);
      end
      main_prev = act;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chain_prev = c2_act;
    end else if (c2_act !== chain_prev) begin
      if (sb_chain.size() == 0) begin
        check("chain_unexpected_edge", c2_act, chain_prev);
      end else begin
        exp_t e;
        e = sb_chain.pop_front();
        check("chain_edge_cycle", cyc, e.cyc);
        check("chain_edge_value", c2_act, e.val);
      end
      chain_prev = c2_act;
    end
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    Start     = 1'b1;
    Sensor    = 1'b1;
    ch_start  = 1'b0;
    ch_sensor = 1'b1;

    // Reset with both inputs high, then release.
    tick(3);
    check("rst_actuator", act, 0);
    check("rst_busy", bsy, 0);
    rst_n = 1'b1;
    push_main(6, 1'b1);
    tick(3);
    check("rel_busy_arm", bsy, 1);
    drain_main(20);
    check("rel_busy_high", bsy, 0);

    Start  = 1'b0;
    Sensor = 1'b0;
    push_main(5, 1'b0);
`ifdef GC_SYNC_RESPONDER_HSCOUNT_EN
    exp_hs++;
`endif
    drain_main(20);

    // Full handshake, Sensor first.
    Sensor = 1'b1;
    tick(5);
    Start = 1'b1;
    push_main(6, 1'b1);
    tick(2);
    check("byp_rise_early", byp_act, 0);
    tick(1);
    check("byp_rise", byp_act, 1);
    check("byp_busy_rise", byp_bsy, 0);
    drain_main(20);
    Start = 1'b0;
    tick(5);
    Sensor = 1'b0;
    push_main(5, 1'b0);
    tick(2);
    check("byp_fall_early", byp_act, 1);
    tick(1);
    check("byp_fall", byp_act, 0);
    check("byp_busy_fall", byp_bsy, 0);
    drain_main(20);
`ifdef GC_SYNC_RESPONDER_HSCOUNT_EN
    exp_hs++;
    check("hs_after_handshake", hs, exp_hs);
`endif

    // Rise glitch: aborted qualification, then a full-latency rise.
    Start  = 1'b1;
    Sensor = 1'b1;
    tick(2);
    Start = 1'b0;
    tick(1);
    check("glitch_busy_arm", bsy, 1);
    tick(5);
    check("glitch_busy_idle", bsy, 0);
    check("glitch_actuator", act, 0);
    Start = 1'b1;
    push_main(6, 1'b1);
    drain_main(20);

    // Hysteresis: only Sensor low holds the output.
    Sensor = 1'b0;
    tick(20);
    check("hyst_actuator", act, 1);
    check("hyst_busy", bsy, 0);
    Start = 1'b0;
    push_main(5, 1'b0);
    drain_main(20);
`ifdef GC_SYNC_RESPONDER_HSCOUNT_EN
    exp_hs++;
    check("hs_after_hyst", hs, exp_hs);
`endif

    // Fall glitch one cycle short of qualifying.
    Start  = 1'b1;
    Sensor = 1'b1;
    push_main(6, 1'b1);
    drain_main(20);
    Start  = 1'b0;
    Sensor = 1'b0;
    tick(2);
    Start  = 1'b1;
    Sensor = 1'b1;
    tick(8);
    check("fall_glitch_actuator", act, 1);
    check("fall_glitch_busy", bsy, 0);

    // Asynchronous reset in the middle of DISARM.
    Start  = 1'b0;
    Sensor = 1'b0;
    tick(4);
    check("disarm_busy", bsy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_actuator", act, 0);
    check("async_rst_busy", bsy, 0);
`ifdef GC_SYNC_RESPONDER_HSCOUNT_EN
    exp_hs = 0;
    check("async_rst_hs", hs, exp_hs);
`endif
    tick(2);
    rst_n = 1'b1;
    tick(10);
    check("post_rst_actuator", act, 0);

    // Three-stage chain on a shared high Sensor.
    begin
      exp_t e;
      ch_start = 1'b1;
      e.cyc = cyc + 18;
      e.val = 1'b1;
      sb_chain.push_back(e);
    end
    begin
      int k = 0;
      while (sb_chain.size() > 0 && k < 40) begin
        @(negedge clk);
        k++;
      end
      if (sb_chain.size() > 0) begin
        check("chain_drain_timeout", sb_chain.size(), 0);
        sb_chain.delete();
      end
    end
    check("chain_stage0", c0_act, 1);
    check("chain_stage1", c1_act, 1);
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gc_sync_responder.md
Name: gc_sync_responder

Overview:
- Clocked, synthesizable responder for the genetic-cell Start/Sensor/Actuator four-phase handshake.
- Sits where a gC cell sits in a sensor-filter chain and answers an environment sequencer.
- Behaves as a filtered Muller C-element:
  - Actuator rises only after Start and Sensor are both stably high.
  - Actuator falls only after both are stably low.
  - Otherwise Actuator holds its value.
- Chains head-to-tail: Actuator of stage k feeds Start of stage k+1.

Parameters:
- SYNC_STAGES, 2: flops in each input synchronizer; legal range 2..4.
- RISE_DLY, 4: consecutive synchronized cycles with both inputs high before Actuator asserts; legal range 1..255.
- FALL_DLY, 3: consecutive synchronized cycles with both inputs low before Actuator deasserts; legal range 1..255.
- CNT_W, 8: width of the internal persistence counter; must satisfy 2^CNT_W > max(RISE_DLY, FALL_DLY).

Ports:
- clk, input, 1: sole clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- Start, input, 1: asynchronous request from the upstream stage or environment.
- Sensor, input, 1: asynchronous environmental sensor level.
- Actuator, output, 1: registered response; a direct flop output.
- busy, output, 1: high while a rise or fall qualification is in progress (ARM or DISARM state).

Behaviour:
- Reset:
  - rst_n low asynchronously clears the synchronizers, counter and Actuator, sets busy=0, and forces state IDLE_LO.
  - Release is synchronous; the first evaluation happens on the first clk edge with rst_n high.
- Synchronizers:
  - Start and Sensor each pass through SYNC_STAGES flops.
  - s_both_hi = sync_start & sync_sensor; s_both_lo = ~sync_start & ~sync_sensor.
- State IDLE_LO (Actuator=0):
  - s_both_hi → ARM with cnt=1.
  - Otherwise stay.
- State ARM (Actuator=0, busy=1):
  - s_both_hi and cnt==RISE_DLY-1 → HIGH; Actuator=1 at that same edge.
  - s_both_hi and cnt<RISE_DLY-1 → cnt+1, stay in ARM.
  - Not s_both_hi (glitch or abort) → IDLE_LO, cnt=0, Actuator stays 0.
- State HIGH (Actuator=1):
  - s_both_lo → DISARM with cnt=1.
  - Otherwise hold. This includes only one input low, which gives C-element hysteresis.
- State DISARM (Actuator=1, busy=1):
  - s_both_lo and cnt==FALL_DLY-1 → IDLE_LO; Actuator=0 at that edge.
  - s_both_lo and cnt<FALL_DLY-1 → cnt+1, stay.
  - Not s_both_lo → back to HIGH, cnt=0.
- RISE_DLY=1 or FALL_DLY=1:
  - Bypass ARM/DISARM.
  - Transition IDLE_LO→HIGH (or HIGH→IDLE_LO) directly on the first qualifying synchronized cycle.
  - busy stays 0 in this case.
- Latency:
  - Input edge to Actuator rise = SYNC_STAGES + RISE_DLY clk edges.
  - Input edge to Actuator fall = SYNC_STAGES + FALL_DLY clk edges.
- Counter:
  - Saturating, never wraps.
  - Cleared on every state entry other than ARM/DISARM continuation.
- Illegal or unreachable state encodings recover to IDLE_LO with Actuator=0 on the next edge.
- Reset asserted mid-ARM or mid-DISARM: Actuator=0 and state IDLE_LO immediately, with no glitch to 1.

Optional Feature:
- Macro: GC_SYNC_RESPONDER_HSCOUNT_EN.
- When defined:
  - Adds output hs_count [15:0].
  - hs_count increments, saturating at 16'hFFFF, on each DISARM→IDLE_LO transition, i.e. each completed four-phase handshake.
  - Cleared by rst_n.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
All scenarios use defaults (SYNC_STAGES=2, RISE_DLY=4, FALL_DLY=3).
1. Reset check: assert rst_n=0 with Start=Sensor=1 → Actuator=0 and busy=0 immediately; release, hold inputs → Actuator=1 exactly 6 edges after release.
2. Full handshake: Sensor=1, then Start=1 5 cycles later → Actuator rises 6 edges after Start; drop Start, then Sensor 5 cycles later → Actuator falls 5 edges after Sensor drops; hs_count=1 when the macro is enabled.
3. Rise glitch: Start=Sensor=1 for 2 cycles, then Start=0 → Actuator stays 0, busy returns to 0, state IDLE_LO.
4. Hysteresis: in HIGH, drop only Sensor for 20 cycles → Actuator stays 1; then drop Start → Actuator falls 5 edges later.
5. Three-stage chain: Actuator of each stage feeds the next stage's Start, all on a shared Sensor=1 → final Actuator rises 18 edges after the first Start.
6. Reset mid-DISARM: assert rst_n low 2 cycles into DISARM → Actuator=0 asynchronously; hs_count=0.
